// File: rtl/dec3to8_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dec3to8_seq_pkg                                                   |
// | Brief  : Shared FSM encoding and one-hot decode for the 3-to-8 sequencer.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package dec3to8_seq_pkg;

   localparam int c_code_w = 3;
   localparam int c_led_w  = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   function automatic logic [c_led_w-1:0] decode_onehot(input logic [c_code_w-1:0] code);
      return 8'b0000_0001 << code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dec3to8_seq_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sync_fifo                                                         |
// | Brief  : Single-clock FIFO; flags come from registered occupancy only.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int                c_ptr_w    = $clog2(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w+1)'(1);
   localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == c_full_cnt);
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dec3to8_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dec3to8_seq                                                       |
// | Brief  : Queued 3-to-8 decoder showing each code for HOLD_CYCLES cycles.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module dec3to8_seq
   import dec3to8_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   output logic       in_ready,
   input  logic       enable,
   output logic [7:0] led_out,
   output logic [2:0] disp_code,
   output logic       no_input
);

   localparam logic [7:0] c_hold_load = 8'(HOLD_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_hold;
   logic [7:0] w_hold_nxt;
   logic [7:0] r_led;
   logic [7:0] w_led_nxt;
   logic [2:0] r_disp;
   logic [2:0] w_disp_nxt;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [2:0] w_head;

   sync_fifo #(
      .WIDTH (c_code_w),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (w_pop),
      .din   (in_code),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_led   <= '0;
         r_disp  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_led   <= w_led_nxt;
         r_disp  <= w_disp_nxt;
      end
   end

   // A pop loads the head into the display; SHOW reloads without a blank cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_led_nxt   = r_led;
      w_disp_nxt  = r_disp;
      w_pop       = 1'b0;
      if (enable) begin
         case (r_state)
            IDLE: begin
               if (!w_empty) w_pop = 1'b1;
            end
            SHOW: begin
               if (r_hold != 8'd0) begin
                  w_hold_nxt = r_hold - 8'd1;
               end else if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_led_nxt   = '0;
                  w_disp_nxt  = '0;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
         if (w_pop) begin
            w_state_nxt = SHOW;
            w_hold_nxt  = c_hold_load;
            w_disp_nxt  = w_head;
            w_led_nxt   = decode_onehot(w_head);
         end
      end
   end

   assign led_out   = r_led;
   assign disp_code = r_disp;
   assign in_ready  = !w_full;
   assign no_input  = (r_state == IDLE) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dec3to8_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dec3to8_seq                                                    |
// | Brief  : Self-checking bench for dec3to8_seq against a queue-based model.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dec3to8_seq;

   localparam int HOLD  = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_code = 3'd0;
   logic       enable = 1'b0;
   logic       in_ready;
   logic [7:0] led_out;
   logic [2:0] disp_code;
   logic       no_input;

   logic       v1 = 1'b0;
   logic [2:0] c1 = 3'd0;
   logic       en1 = 1'b1;
   logic       rdy1;
   logic [7:0] led1;
   logic [2:0] disp1;
   logic       noin1;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a list of waiting codes plus the code on display and its remaining enabled cycles.
   logic [2:0] m_q[$];
   bit         m_show;
   logic [2:0] m_cur;
   int         m_rem;

   logic [12:0] dut_out;
   assign dut_out = {led_out, disp_code, in_ready, no_input};

   always #5 clk = ~clk;

   dec3to8_seq #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
      .enable(enable), .led_out(led_out), .disp_code(disp_code), .no_input(no_input)
   );

   dec3to8_seq #(.HOLD_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_code(c1), .in_ready(rdy1),
      .enable(en1), .led_out(led1), .disp_code(disp1), .no_input(noin1)
   );

   function automatic logic [12:0] model_out();
      logic [7:0] l;
      logic [2:0] d;
      l = 8'd0;
      d = 3'd0;
      if (m_show) begin
         l = 8'd1 << m_cur;
         d = m_cur;
      end
      return {l, d, (m_q.size() < DEPTH), (!m_show && m_q.size() == 0)};
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_show = 1'b0;
      m_cur  = 3'd0;
      m_rem  = 0;
   endfunction

   task automatic tick();
      bit         acc;
      logic [2:0] c;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         acc = in_valid && (m_q.size() < DEPTH);
         c   = in_code;
         if (enable) begin
            if (m_show) begin
               m_rem--;
               if (m_rem == 0) begin
                  if (m_q.size() > 0) begin
                     m_cur = m_q.pop_front();
                     m_rem = HOLD;
                  end else begin
                     m_show = 1'b0;
                  end
               end
            end else if (m_q.size() > 0) begin
               m_cur  = m_q.pop_front();
               m_rem  = HOLD;
               m_show = 1'b1;
            end
         end
         if (acc) m_q.push_back(c);
      end
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      enable   = 1'b1;
      for (int i = 0; i < 24; i++) tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if (dut_out !== {8'h00, 3'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_held got=%h exp=%h", dut_out, {8'h00, 3'd0, 1'b1, 1'b1});
      end
      rst_n = 1'b1;
      enable = 1'b1;
      tick();
      n_checks++;
      if (dut_out !== {8'h00, 3'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_released got=%h exp=%h", dut_out, {8'h00, 3'd0, 1'b1, 1'b1});
      end
      n_checks++;
      if ({led1, rdy1, noin1} !== {8'h00, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_dut1 got=%h exp=%h", {led1, rdy1, noin1}, {8'h00, 1'b1, 1'b1});
      end
   endtask

   task automatic test_single_code();
      logic [7:0] exp;
      in_valid = 1'b1;
      in_code  = 3'd5;
      for (int i = 0; i < 6; i++) begin
         tick();
         in_valid = 1'b0;
         exp = (i >= 1 && i <= 4) ? 8'h20 : 8'h00;
         n_checks++;
         if (led_out !== exp) begin
            n_fail++;
            $display("FAIL single_led cyc=%0d got=%h exp=%h", i, led_out, exp);
         end
         n_checks++;
         if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL single_model cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
      end
      n_checks++;
      if (no_input !== 1'b1) begin
         n_fail++;
         $display("FAIL single_no_input got=%b exp=1", no_input);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] codes [3];
      logic [7:0] exp;
      codes[0] = 3'd0;
      codes[1] = 3'd7;
      codes[2] = 3'd3;
      for (int i = 0; i < 14; i++) begin
         in_valid = (i < 3);
         in_code  = (i < 3) ? codes[i] : 3'd0;
         tick();
         if (i == 0 || i == 13) exp = 8'h00;
         else if (i <= 4)       exp = 8'h01;
         else if (i <= 8)       exp = 8'h80;
         else                   exp = 8'h08;
         n_checks++;
         if (led_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_led cyc=%0d got=%h exp=%h", i, led_out, exp);
         end
         n_checks++;
         if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_freeze();
      logic [7:0] exp;
      in_valid = 1'b1;
      in_code  = 3'd2;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         enable = !(i >= 2 && i <= 4);
         tick();
         exp = (i <= 6) ? 8'h04 : 8'h00;
         n_checks++;
         if (led_out !== exp) begin
            n_fail++;
            $display("FAIL freeze_led cyc=%0d got=%h exp=%h", i, led_out, exp);
         end
         n_checks++;
         if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL freeze_model cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
      end
      enable = 1'b1;
   endtask

   task automatic test_full_queue();
      logic [7:0] seen[$];
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_code  = 3'(k + 1);
         n_checks++;
         if (in_ready !== (k < 4)) begin
            n_fail++;
            $display("FAIL full_ready k=%0d got=%b exp=%b", k, in_ready, (k < 4));
         end
         tick();
      end
      in_valid = 1'b0;
      enable   = 1'b1;
      tick();
      n_checks++;
      if ({led_out, in_ready} !== {8'h02, 1'b1}) begin
         n_fail++;
         $display("FAIL full_first_pop got=%h exp=%h", {led_out, in_ready}, {8'h02, 1'b1});
      end
      seen.push_back(led_out);
      for (int i = 0; i < 18; i++) begin
         tick();
         if (led_out != 8'h00 && led_out != seen[$]) seen.push_back(led_out);
         n_checks++;
         if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL full_model cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
      end
      n_checks++;
      if (seen.size() != 4) begin
         n_fail++;
         $display("FAIL full_count got=%0d exp=4", seen.size());
      end
      for (int i = 0; i < seen.size() && i < 4; i++) begin
         n_checks++;
         if (seen[i] !== (8'd1 << (i + 1))) begin
            n_fail++;
            $display("FAIL full_order idx=%0d got=%h exp=%h", i, seen[i], 8'd1 << (i + 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_code  = 3'(k + 4);
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (led_out !== 8'h10) begin
         n_fail++;
         $display("FAIL rstmid_pre got=%h exp=10", led_out);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dut_out !== {8'h00, 3'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL rstmid_async got=%h exp=%h", dut_out, {8'h00, 3'd0, 1'b1, 1'b1});
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (led_out !== 8'h00 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
      end
   endtask

   task automatic test_hold1();
      logic [7:0] exp [4];
      exp[0] = 8'h00;
      exp[1] = 8'h02;
      exp[2] = 8'h40;
      exp[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         v1 = (i < 2);
         c1 = (i == 0) ? 3'd1 : 3'd6;
         tick();
         n_checks++;
         if (led1 !== exp[i]) begin
            n_fail++;
            $display("FAIL hold1_led cyc=%0d got=%h exp=%h", i, led1, exp[i]);
         end
      end
      v1 = 1'b0;
      n_checks++;
      if (noin1 !== 1'b1) begin
         n_fail++;
         $display("FAIL hold1_no_input got=%b exp=1", noin1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_code  = 3'($urandom_range(0, 7));
         enable   = ($urandom_range(0, 3) != 0);
         tick();
         n_checks++;
         if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_out, model_out());
         end
         n_checks++;
         if (($countones(led_out) > 1) || (led_out !== 8'h00 && led_out !== (8'd1 << disp_code))) begin
            n_fail++;
            $display("FAIL random_onehot cyc=%0d led=%h disp=%0d", i, led_out, disp_code);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_code();
      drain();
      test_back_to_back();
      drain();
      test_freeze();
      drain();
      test_full_queue();
      drain();
      test_reset_mid();
      test_hold1();
      drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
